// File: rtl/regfile_alu_sequencer.sv
// Purpose: sequences one register-file read / ALU execute / write-back command at a time (IDLE->READ->EXEC->WRITE).
// Latency: write edge is 3 cycles after the accept edge; a new command is accepted every 4 cycles.
// Backpressure: cmd_ready is high only in IDLE. Optional signed-overflow trap when SEQ_OVF_TRAP_EN is defined.
module regfile_alu_sequencer (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [3:0]         cmd_op,
    input  logic [4:0]         cmd_rs,
    input  logic [4:0]         cmd_rt,
    input  logic [4:0]         cmd_rd,
    input  logic [4:0]         cmd_shamt,
    input  logic               cmd_wb,
    output logic [4:0]         rf_rr1,
    output logic [4:0]         rf_rr2,
    input  logic signed [31:0] rf_rdata1,
    input  logic signed [31:0] rf_rdata2,
    output logic [4:0]         rf_wr,
    output logic [31:0]        rf_wd,
    output logic               rf_we,
    output logic [3:0]         alu_op,
    output logic [4:0]         alu_shamt,
    input  logic [31:0]        alu_result,
    output logic [31:0]        result,
    output logic               done,
    output logic               err
);

    typedef enum logic [1:0] {S_IDLE, S_READ, S_EXEC, S_WRITE} state_t;

    state_t      state_q, state_d;
    logic [3:0]  op_q;
    logic [4:0]  rs_q, rt_q, rd_q, shamt_q;
    logic        wb_q;
    logic [31:0] result_q;
    logic [3:0]  alu_op_q;
    logic        accept;
    logic        legal;
    logic        trap;

    assign accept = cmd_valid && (state_q == S_IDLE);
    assign result = result_q;

    // State register; reset aborts any command in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: every non-idle state lasts exactly one cycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (accept) state_d = S_READ;
            S_READ:  state_d = S_EXEC;
            S_EXEC:  state_d = S_WRITE;
            S_WRITE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Command fields are held for the whole life of the command.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q    <= '0;
            rs_q    <= '0;
            rt_q    <= '0;
            rd_q    <= '0;
            shamt_q <= '0;
            wb_q    <= 1'b0;
        end else if (accept) begin
            op_q    <= cmd_op;
            rs_q    <= cmd_rs;
            rt_q    <= cmd_rt;
            rd_q    <= cmd_rd;
            shamt_q <= cmd_shamt;
            wb_q    <= cmd_wb;
        end
    end

    // Capture the ALU result leaving EXEC; remember the op so alu_op holds afterwards.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result_q <= '0;
            alu_op_q <= '0;
        end else if (state_q == S_EXEC) begin
            result_q <= alu_result;
            alu_op_q <= op_q;
        end
    end

    // Op codes the ALU implements; anything else errors and skips write-back.
    always_comb begin
        case (op_q)
            4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111,
            4'b1000, 4'b1100, 4'b1101, 4'b1110, 4'b1111: legal = 1'b1;
            default:                                     legal = 1'b0;
        endcase
    end

`ifdef SEQ_OVF_TRAP_EN
    logic [31:0] opa_q, opb_q;

    // Operands are captured alongside the result so the trap sees a consistent triple.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            opa_q <= '0;
            opb_q <= '0;
        end else if (state_q == S_EXEC) begin
            opa_q <= rf_rdata1;
            opb_q <= rf_rdata2;
        end
    end

    // Signed overflow for add (0010) and subtract (0110).
    always_comb begin
        trap = 1'b0;
        if (op_q == 4'b0010) begin
            trap = (opa_q[31] == opb_q[31]) && (result_q[31] != opa_q[31]);
        end else if (op_q == 4'b0110) begin
            trap = (opa_q[31] != opb_q[31]) && (result_q[31] != opa_q[31]);
        end
    end
`else
    // Read data only feeds the overflow trap, which is absent in this build.
    logic unused_rdata;
    assign unused_rdata = ^{rf_rdata1, rf_rdata2};
    assign trap = 1'b0;
`endif

    // Outputs decoded from the current state.
    always_comb begin
        cmd_ready = (state_q == S_IDLE);
        rf_rr1    = '0;
        rf_rr2    = '0;
        rf_wr     = '0;
        rf_wd     = '0;
        rf_we     = 1'b0;
        alu_op    = alu_op_q;
        alu_shamt = '0;
        done      = 1'b0;
        err       = 1'b0;
        case (state_q)
            S_READ: begin
                rf_rr1 = rs_q;
                rf_rr2 = rt_q;
            end
            S_EXEC: begin
                rf_rr1    = rs_q;
                rf_rr2    = rt_q;
                alu_op    = op_q;
                alu_shamt = shamt_q;
            end
            S_WRITE: begin
                rf_wr = rd_q;
                rf_wd = result_q;
                rf_we = wb_q && legal && !trap;
                done  = 1'b1;
                err   = !legal || trap;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_regfile_alu_sequencer.sv
module tb_regfile_alu_sequencer;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               cmd_valid = 1'b0;
    logic               cmd_ready;
    logic [3:0]         cmd_op = '0;
    logic [4:0]         cmd_rs = '0, cmd_rt = '0, cmd_rd = '0, cmd_shamt = '0;
    logic               cmd_wb = 1'b0;
    logic [4:0]         rf_rr1, rf_rr2, rf_wr;
    logic signed [31:0] rf_rdata1 = '0, rf_rdata2 = '0;
    logic [31:0]        rf_wd;
    logic               rf_we;
    logic [3:0]         alu_op;
    logic [4:0]         alu_shamt;
    logic [31:0]        alu_result;
    logic [31:0]        result;
    logic               done, err;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    always #5 clk = ~clk;

    regfile_alu_sequencer dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_rs(cmd_rs), .cmd_rt(cmd_rt), .cmd_rd(cmd_rd),
        .cmd_shamt(cmd_shamt), .cmd_wb(cmd_wb),
        .rf_rr1(rf_rr1), .rf_rr2(rf_rr2), .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
        .rf_wr(rf_wr), .rf_wd(rf_wd), .rf_we(rf_we),
        .alu_op(alu_op), .alu_shamt(alu_shamt), .alu_result(alu_result),
        .result(result), .done(done), .err(err)
    );

    // ---------------- reference arithmetic ----------------
    function automatic logic [31:0] alu_f(input logic [3:0] op, input logic [31:0] a,
                                          input logic [31:0] b, input logic [4:0] sh);
        case (op)
            4'b0000: return a & b;
            4'b0001: return a | b;
            4'b0010: return a + b;
            4'b0110: return a - b;
            4'b0111: return {31'b0, ($signed(a) < $signed(b))};
            4'b1000: return a ^ b;
            4'b1100: return ~(a | b);
            4'b1101: return a << sh;
            4'b1110: return a >> sh;
            4'b1111: return $signed(a) >>> sh;
            default: return 32'hDEADBEEF;
        endcase
    endfunction

    function automatic bit is_legal(input logic [3:0] op);
        return op inside {4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111,
                          4'b1000, 4'b1100, 4'b1101, 4'b1110, 4'b1111};
    endfunction

    function automatic bit ovf(input logic [3:0] op, input logic [31:0] a,
                               input logic [31:0] b, input logic [31:0] r);
        if (op == 4'b0010) return (a[31] == b[31]) && (r[31] != a[31]);
        if (op == 4'b0110) return (a[31] != b[31]) && (r[31] != a[31]);
        return 1'b0;
    endfunction

    // ---------------- environment: register file and ALU ----------------
    logic [31:0] rf [32];
    logic        init_req = 1'b1;
    logic        poke_vld = 1'b0;
    logic [4:0]  poke_addr = '0;
    logic [31:0] poke_dat = '0;

    always @(negedge clk) begin
        rf_rdata1 <= rf[rf_rr1];
        rf_rdata2 <= rf[rf_rr2];
    end

    assign alu_result = alu_f(alu_op, rf_rdata1, rf_rdata2, alu_shamt);

    // ---------------- transaction-level model ----------------
    logic [31:0] m_rf [32];
    int          age = 0;          // cycles since accept of the command in flight, 0 = none
    logic [3:0]  t_op = '0;
    logic [4:0]  t_rs = '0, t_rt = '0, t_rd = '0, t_sh = '0;
    logic [31:0] t_res = '0;
    bit          t_err = 1'b0, t_we = 1'b0;
    logic [31:0] m_result = '0;
    logic [3:0]  m_last_op = '0;
    bit          idle_pre;
    logic [31:0] ma, mb;

    always @(posedge clk) begin
        cyc++;
        if (init_req) begin
            for (int i = 0; i < 32; i++) begin
                rf[i] <= 32'(i);
                m_rf[i] = 32'(i);
            end
        end else if (poke_vld) begin
            rf[poke_addr] <= poke_dat;
            m_rf[poke_addr] = poke_dat;
        end else if (rf_we) begin
            rf[rf_wr] <= rf_wd;
        end
        if (!rst_n) begin
            age = 0;
            m_result = '0;
            m_last_op = '0;
        end else begin
            idle_pre = (age == 0);
            if (age == 2) begin
                m_result = t_res;
                m_last_op = t_op;
            end
            if (age == 3) begin
                if (t_we) m_rf[t_rd] = t_res;
                age = 0;
            end else if (age != 0) begin
                age++;
            end
            if (idle_pre && cmd_valid) begin
                t_op = cmd_op; t_rs = cmd_rs; t_rt = cmd_rt; t_rd = cmd_rd; t_sh = cmd_shamt;
                ma = m_rf[cmd_rs];
                mb = m_rf[cmd_rt];
                t_res = alu_f(cmd_op, ma, mb, cmd_shamt);
`ifdef SEQ_OVF_TRAP_EN
                t_err = !is_legal(cmd_op) || ovf(cmd_op, ma, mb, t_res);
`else
                t_err = !is_legal(cmd_op);
`endif
                t_we = cmd_wb && !t_err;
                age = 1;
            end
        end
    end

    // ---------------- checking helpers ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic chkb(input string name, input logic act, input logic exp);
        chk(name, {31'b0, act}, {31'b0, exp});
    endtask

    task automatic chk_timeout(input string name);
        total++;
        bad++;
        $display("FAIL %s: timed out (cycle %0d)", name, cyc);
    endtask

    // Per-cycle comparison of every meaningful output against the model.
    always @(posedge clk) begin
        #2;
        if (rst_n && !init_req) begin
            chkb("cmd_ready", cmd_ready, age == 0);
            chkb("done", done, age == 3);
            chkb("err", err, (age == 3) && t_err);
            chkb("rf_we", rf_we, (age == 3) && t_we);
            chk("result", result, m_result);
            chk("alu_op", {28'b0, alu_op}, {28'b0, (age == 2) ? t_op : m_last_op});
            chk("alu_shamt", {27'b0, alu_shamt}, {27'b0, (age == 2) ? t_sh : 5'd0});
            if (age == 1 || age == 2) begin
                chk("rf_rr1", {27'b0, rf_rr1}, {27'b0, t_rs});
                chk("rf_rr2", {27'b0, rf_rr2}, {27'b0, t_rt});
            end
            if (age == 3) begin
                chk("rf_wr", {27'b0, rf_wr}, {27'b0, t_rd});
                chk("rf_wd", rf_wd, t_res);
            end
        end
    end

    // ---------------- stimulus tasks ----------------
    task automatic do_init();
        @(negedge clk);
        init_req = 1'b1;
        @(posedge clk);
        #1 init_req = 1'b0;
    endtask

    task automatic poke(input logic [4:0] a, input logic [31:0] d);
        @(negedge clk);
        poke_vld = 1'b1; poke_addr = a; poke_dat = d;
        @(posedge clk);
        #1 poke_vld = 1'b0;
    endtask

    task automatic wait_idle();
        bit ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (cmd_ready) begin ok = 1'b1; break; end
        end
        if (!ok) chk_timeout("wait_idle");
    endtask

    // Present a command; returns just after the accept edge (in READ).
    task automatic send(input logic [3:0] op, input logic [4:0] rs, input logic [4:0] rt,
                        input logic [4:0] rd, input logic [4:0] sh, input logic wb,
                        input bit hold, output int acc);
        @(negedge clk);
        cmd_op = op; cmd_rs = rs; cmd_rt = rt; cmd_rd = rd; cmd_shamt = sh; cmd_wb = wb;
        cmd_valid = 1'b1;
        acc = -1;
        for (int i = 0; i < 40; i++) begin
            if (cmd_ready) begin
                @(posedge clk);
                #1 acc = cyc;
                break;
            end
            @(negedge clk);
        end
        if (acc < 0) chk_timeout("accept");
        if (!hold) cmd_valid = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // ---------------- main sequence ----------------
    int  a1, a2;
    bit  hold;

    initial begin
        repeat (3) @(posedge clk);
        #1 init_req = 1'b0;
        // reset values
        chkb("rst_rf_we", rf_we, 1'b0);
        chkb("rst_done", done, 1'b0);
        chkb("rst_err", err, 1'b0);
        chk("rst_result", result, 32'h0);
        chk("rst_rr1", {27'b0, rf_rr1}, 32'h0);
        chk("rst_rr2", {27'b0, rf_rr2}, 32'h0);
        chk("rst_wr", {27'b0, rf_wr}, 32'h0);
        chk("rst_wd", rf_wd, 32'h0);
        chk("rst_alu_op", {28'b0, alu_op}, 32'h0);
        chk("rst_alu_shamt", {27'b0, alu_shamt}, 32'h0);
        @(negedge clk) rst_n = 1'b1;
        step();
        chkb("rst_ready", cmd_ready, 1'b1);

        // add r3 + r31 -> r5
        do_init();
        send(4'b0010, 5'd3, 5'd31, 5'd5, 5'd0, 1'b1, 1'b0, a1);
        step();
        chkb("add_we_exec", rf_we, 1'b0);
        step();
        chkb("add_we", rf_we, 1'b1);
        chk("add_wr", {27'b0, rf_wr}, 32'd5);
        chk("add_wd", rf_wd, 32'd34);
        chkb("add_done", done, 1'b1);
        chk("add_r5_before", rf[5], 32'd5);
        step();
        chk("add_r5", rf[5], 32'd34);

        // sub then and with cmd_valid held
        do_init();
        send(4'b0110, 5'd3, 5'd0, 5'd6, 5'd0, 1'b1, 1'b1, a1);
        send(4'b0000, 5'd6, 5'd5, 5'd10, 5'd0, 1'b0, 1'b0, a2);
        chk("b2b_gap", 32'(a2 - a1), 32'd4);
        repeat (3) step();
        chk("b2b_r6", rf[6], 32'd3);
        chk("b2b_result", result, 32'd1);

        // illegal op
        do_init();
        send(4'b0011, 5'd1, 5'd2, 5'd7, 5'd0, 1'b1, 1'b0, a1);
        repeat (2) step();
        chkb("ill_err", err, 1'b1);
        chkb("ill_done", done, 1'b1);
        chkb("ill_we", rf_we, 1'b0);
        step();
        chk("ill_r7", rf[7], 32'd7);

        // SRA without write-back
        poke(5'd0, 32'hFFFFFFF8);
        send(4'b1111, 5'd0, 5'd4, 5'd3, 5'd2, 1'b0, 1'b0, a1);
        repeat (2) step();
        chkb("sra_done", done, 1'b1);
        chkb("sra_we", rf_we, 1'b0);
        chk("sra_result", result, 32'hFFFFFFFE);

        // signed overflow on add
        do_init();
        poke(5'd1, 32'h7FFFFFFF);
        poke(5'd2, 32'd1);
        send(4'b0010, 5'd1, 5'd2, 5'd8, 5'd0, 1'b1, 1'b0, a1);
        repeat (2) step();
`ifdef SEQ_OVF_TRAP_EN
        chkb("ovf_err", err, 1'b1);
        step();
        chk("ovf_r8", rf[8], 32'd8);
`else
        chkb("ovf_err", err, 1'b0);
        step();
        chk("ovf_r8", rf[8], 32'h80000000);
`endif

        // reset during EXEC
        do_init();
        send(4'b0010, 5'd1, 5'd2, 5'd9, 5'd0, 1'b1, 1'b0, a1);
        step();
        rst_n = 1'b0;
        #1;
        chkb("abort_done", done, 1'b0);
        chkb("abort_we", rf_we, 1'b0);
        chk("abort_result", result, 32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        step();
        chkb("abort_ready", cmd_ready, 1'b1);
        chk("abort_r9", rf[9], 32'd9);

        // randomized traffic
        do_init();
        hold = 1'b0;
        for (int n = 0; n < 300; n++) begin
            if (!hold) begin
                if ($urandom_range(0, 5) == 0) begin
                    wait_idle();
                    poke(5'($urandom_range(0, 31)), $urandom);
                end
                repeat ($urandom_range(0, 2)) @(negedge clk);
            end
            hold = ($urandom_range(0, 2) == 0) && (n < 299);
            send(4'($urandom_range(0, 15)), 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
                 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)),
                 hold, a1);
        end
        cmd_valid = 1'b0;
        wait_idle();
        step();
        for (int i = 0; i < 32; i++) chk($sformatf("final_r%0d", i), rf[i], m_rf[i]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

endmodule
